pipe_stage_skid: RTL and testbench
==================================

// Module: pipe_stage_skid
// PURPOSE
//  Parametrised elastic pipeline-stage register for the RV32I core (IF/ID, ID/EX, EX/MEM, MEM/WB).
//  Carries a control field and N data words, with valid/ready handshake, flush and an optional 2-entry skid buffer.
//  Downstream back-pressure does not need a combinational ready path upstream.
//  Counts stall cycles for performance analysis.
// PARAMETERS
//  DATA_W  32  width of each data word (e.g. ALUResult, ReadData, PCPlus4)
//  N_DATA  3   number of data words carried
//  CTRL_W  8   control field width (e.g. {RegWrite,ResultSrc[1:0],Rd[4:0]}); zeroed on bubble/flush
//  SKID    1   1: 2-entry skid buffer, in_ready registered; 0: single entry, in_ready = out_ready | ~out_valid
//  STAT_W  16  stall-counter width
// PORTS
//  clk        in   1               clock, all state updates on rising edge
//  rst        in   1               synchronous reset, active-high
//  flush      in   1               synchronous flush (hazard unit), discards all held entries
//  in_valid   in   1               upstream entry valid
//  in_ready   out  1               stage can accept an entry this cycle
//  in_ctrl    in   CTRL_W          upstream control field
//  in_data    in   N_DATA*DATA_W   upstream data words, word k at [k*DATA_W +: DATA_W]
//  out_valid  out  1               head entry valid
//  out_ready  in   1               downstream accepts head entry (0 = stall)
//  out_ctrl   out  CTRL_W          head control field; forced 0 when out_valid=0
//  out_data   out  N_DATA*DATA_W   head data words
//  stall_cnt  out  STAT_W          cycles with out_valid=1 and out_ready=0
// BEHAVIOUR
//  - Reset (rst=1 at edge): out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid entry empty.
//    in_ready=0 while rst=1 and 1 in the first cycle after rst deasserts.
//  - Transfer in: in_valid & in_ready. Transfer out: out_valid & out_ready.
//    Latency is 1 cycle from input transfer to out_valid. Throughput is 1 entry/cycle when out_ready is held at 1.
//  - SKID=1 state machine, state encodes occupancy:
//    EMPTY: in_ready=1, out_valid=0. Input transfer -> FULL (head loaded).
//    FULL:  in_ready=1, out_valid=1.
//      in & out       -> FULL, head <= input.
//      in & ~out      -> SKID, input goes to skid register.
//      ~in & out      -> EMPTY.
//      ~in & ~out     -> FULL, hold.
//    SKID:  in_ready=0, out_valid=1.
//      out transfer   -> FULL, head <= skid.
//      no out transfer -> hold.
//    in_ready is a registered function of state only; no comb path from out_ready.
//  - SKID=0: single head register. in_ready = out_ready | ~out_valid.
//    Head loads on input transfer and clears valid on an out transfer with no input.
//  - Entries are never dropped or duplicated. Order is FIFO.
//    Head data is stable while out_valid=1 and out_ready=0.
//  - flush=1 at edge: next state EMPTY, out_valid=0, out_ctrl=0, skid discarded.
//    An input presented in the same cycle is discarded; in_ready still reads 1 so upstream sees a transfer.
//    Data registers may hold stale values; they must not be observable via out_ctrl.
//  - Priority: rst > flush > normal operation.
//    Reset mid-operation discards all entries and clears stall_cnt.
//  - stall_cnt increments by 1 each cycle with out_valid & ~out_ready & ~flush.
//    It saturates at all-ones and does not wrap.
//  - out_ctrl = head_ctrl & {CTRL_W{out_valid}}, so bubbles can never assert RegWrite.
// TESTING
//  1 Reset: rst=1 for 2 cycles with random inputs -> out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, in_ready=0;
//    cycle after release in_ready=1.
//  2 Streaming: 8 entries (data word0=0x1000+i, ctrl=i), out_ready=1 ->
//    out sees word0 0x1000..0x1007 in order, one per cycle, 1-cycle latency.
//  3 Back-pressure: hold out_ready=0 while pushing A=0xAAAA0001, B=0xBBBB0002 ->
//    in_ready falls after B, head=A stable, stall_cnt counts each stalled cycle.
//    Release -> A then B, no loss.
//  4 Flush in SKID state with in_valid=1, C=0xCCCC0003 ->
//    next cycle out_valid=0, out_ctrl=0; C never appears; next push D appears normally.
//  5 Saturation: STAT_W=4, stall 20 cycles -> stall_cnt=15 and stays 15; rst -> 0.
//  6 SKID=0 build: repeat tests 2-4 -> same output ordering.
//    in_ready tracks out_ready combinationally while full.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register for the RV32I core: control field plus N data words,
// valid/ready handshake, flush, optional 2-entry skid buffer and a saturating stall counter.
module pipe_stage_skid #(
  parameter int DATA_W = 32,
  parameter int N_DATA = 3,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1,
  parameter int STAT_W = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CTRL_W-1:0]          in_ctrl,
  input  logic [N_DATA*DATA_W-1:0]   in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CTRL_W-1:0]          out_ctrl,
  output logic [N_DATA*DATA_W-1:0]   out_data,
  output logic [STAT_W-1:0]          stall_cnt
);

  localparam int DW = N_DATA * DATA_W;

  // Occupancy: EMPTY = 0 entries, FULL = head only, SKID = head + skid entry.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [CTRL_W-1:0]   head_ctrl_q, head_ctrl_d;
  logic [DW-1:0]       head_data_q, head_data_d;
  logic [CTRL_W-1:0]   skid_ctrl_q, skid_ctrl_d;
  logic [DW-1:0]       skid_data_q, skid_data_d;
  logic [STAT_W-1:0]   stall_q, stall_d;
  logic                base_ready;
  logic                in_xfer;
  logic                out_xfer;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_comb begin
    out_valid = (state_q != ST_EMPTY);
    if (SKID != 0) begin
      // Ready depends only on the registered state; no path from out_ready.
      base_ready = (state_q != ST_SKID);
    end else begin
      base_ready = out_ready | ~out_valid;
    end
    // During flush the stage swallows whatever is presented so upstream can move on.
    in_ready  = ~rst & (flush | base_ready);
    in_xfer   = in_valid & in_ready;
    out_xfer  = out_valid & out_ready;
    out_ctrl  = head_ctrl_q & {CTRL_W{out_valid}};
    out_data  = head_data_q;
    stall_cnt = stall_q;
  end

  always_comb begin
    state_d     = state_q;
    head_ctrl_d = head_ctrl_q;
    head_data_d = head_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    stall_d     = stall_q;

    if (out_valid & ~out_ready & ~flush) begin
      stall_d = sat_inc(stall_q);
    end

    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d     = ST_FULL;
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end
        end
        ST_FULL: begin
          if (in_xfer && out_xfer) begin
            head_ctrl_d = in_ctrl;
            head_data_d = in_data;
          end else if (in_xfer) begin
            if (SKID != 0) begin
              state_d     = ST_SKID;
              skid_ctrl_d = in_ctrl;
              skid_data_d = in_data;
            end else begin
              head_ctrl_d = in_ctrl;
              head_data_d = in_data;
            end
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_SKID: begin
          if (out_xfer) begin
            state_d     = ST_FULL;
            head_ctrl_d = skid_ctrl_q;
            head_data_d = skid_data_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Stage register boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_EMPTY;
      head_ctrl_q <= '0;
      head_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
      stall_q     <= '0;
    end else begin
      state_q     <= state_d;
      head_ctrl_q <= head_ctrl_d;
      head_data_q <= head_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
      stall_q     <= stall_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: three builds (skid/16-bit counter, no-skid, skid/4-bit counter)
// share one stimulus stream and are compared every cycle against a queue-occupancy model.
module tb_pipe_stage_skid;
  localparam int EW = 104;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [7:0]  in_ctrl;
  logic [95:0] in_data;
  logic [2:0]  ir, ov;
  logic [7:0]  oc0, oc1, oc2;
  logic [95:0] od0, od1, od2;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  pipe_stage_skid #(.DATA_W(32), .N_DATA(3), .CTRL_W(8), .SKID(1), .STAT_W(16)) u_d0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[0]), .out_ready(out_ready),
    .out_ctrl(oc0), .out_data(od0), .stall_cnt(sc0));
  pipe_stage_skid #(.DATA_W(32), .N_DATA(3), .CTRL_W(8), .SKID(0), .STAT_W(16)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[1]), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1), .stall_cnt(sc1));
  pipe_stage_skid #(.DATA_W(32), .N_DATA(3), .CTRL_W(8), .SKID(1), .STAT_W(4)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(ov[2]), .out_ready(out_ready),
    .out_ctrl(oc2), .out_data(od2), .stall_cnt(sc2));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  logic [EW-1:0] m_ent [3][2];
  int            m_cnt [3];
  int            m_stall [3];
  int            sat_max [3] = '{65535, 65535, 15};
  bit            is_skid [3] = '{1'b1, 1'b0, 1'b1};

  bit            chk_en = 1'b0;
  bit            cap_en = 1'b0;
  logic [31:0]   cap [3][64];
  int            cap_n [3];
  logic [31:0]   exp_w [8];
  int            exp_n;

  task automatic chk(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] f_oc(input int k);
    case (k)
      0:       return oc0;
      1:       return oc1;
      default: return oc2;
    endcase
  endfunction

  function automatic logic [95:0] f_od(input int k);
    case (k)
      0:       return od0;
      1:       return od1;
      default: return od2;
    endcase
  endfunction

  function automatic logic [15:0] f_sc(input int k);
    case (k)
      0:       return sc0;
      1:       return sc1;
      default: return {12'b0, sc2};
    endcase
  endfunction

  function automatic logic m_rdy(input int k);
    if (rst)              return 1'b0;
    else if (flush)       return 1'b1;
    else if (is_skid[k])  return (m_cnt[k] < 2);
    else                  return (out_ready || m_cnt[k] == 0);
  endfunction

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      logic [EW-1:0] head;
      logic          vld;
      head = m_ent[k][0];
      vld  = (m_cnt[k] > 0);
      chk($sformatf("d%0d.in_ready", k), EW'(ir[k]), EW'(m_rdy(k)));
      chk($sformatf("d%0d.out_valid", k), EW'(ov[k]), EW'(vld));
      chk($sformatf("d%0d.out_ctrl", k), EW'(f_oc(k)), vld ? EW'(head[103:96]) : '0);
      if (vld) chk($sformatf("d%0d.out_data", k), EW'(f_od(k)), EW'(head[95:0]));
      chk($sformatf("d%0d.stall_cnt", k), EW'(f_sc(k)), EW'(m_stall[k]));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < 3; k++) begin
      logic r;
      r = m_rdy(k);
      if (rst) begin
        m_cnt[k]   = 0;
        m_stall[k] = 0;
      end else begin
        if (m_cnt[k] > 0 && !out_ready && !flush && m_stall[k] < sat_max[k]) m_stall[k]++;
        if (flush) begin
          m_cnt[k] = 0;
        end else begin
          if (m_cnt[k] > 0 && out_ready) begin
            m_ent[k][0] = m_ent[k][1];
            m_cnt[k]--;
          end
          if (in_valid && r) begin
            m_ent[k][m_cnt[k]] = {in_ctrl, in_data};
            m_cnt[k]++;
          end
        end
      end
    end
  endtask

  // One clock: check before the edge, advance the model at the edge, return at the next negedge.
  task automatic cyc();
    #2;
    if (chk_en) check_outputs();
    if (cap_en) begin
      for (int k = 0; k < 3; k++) begin
        logic [95:0] d;
        d = f_od(k);
        if (ov[k] && out_ready && cap_n[k] < 64) begin
          cap[k][cap_n[k]] = d[31:0];
          cap_n[k]++;
        end
      end
    end
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic cap_clear();
    for (int k = 0; k < 3; k++) cap_n[k] = 0;
  endtask

  task automatic check_cap(input string name);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s.d%0d.count", name, k), EW'(cap_n[k]), EW'(exp_n));
      for (int i = 0; i < exp_n; i++)
        chk($sformatf("%s.d%0d.word%0d", name, k, i), EW'(cap[k][i]), EW'(exp_w[i]));
    end
  endtask

  task automatic rand_data();
    in_ctrl = 8'($urandom);
    in_data = {$urandom, $urandom, $urandom};
  endtask

  task automatic push_word(input logic [7:0] c, input logic [31:0] w);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = {$urandom, $urandom, w};
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0;
      m_stall[k] = 0;
      m_ent[k][0] = '0;
      m_ent[k][1] = '0;
    end
    cap_clear();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_data = '0;
    @(negedge clk);

    // Reset with random inputs
    in_valid = 1'b1; out_ready = 1'b0; rand_data();
    cyc();
    chk_en = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1; rand_data();
    cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst.d%0d.out_data", k), EW'(f_od(k)), '0);
      chk($sformatf("rst.d%0d.in_ready_held", k), EW'(ir[k]), '0);
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) chk($sformatf("rst.d%0d.in_ready_release", k), EW'(ir[k]), EW'(1));
    cyc();

    // Streaming 8 entries at full rate
    cap_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(8'(i), 32'h1000 + 32'(i));
      cyc();
    end
    in_valid = 1'b0;
    cyc();
    cyc();
    exp_n = 8;
    for (int i = 0; i < 8; i++) exp_w[i] = 32'h1000 + 32'(i);
    check_cap("stream");

    // Back-pressure with A then B
    cap_clear();
    out_ready = 1'b0;
    push_word(8'h0A, 32'hAAAA0001);
    cyc();
    push_word(8'h0B, 32'hBBBB0002);
    cyc();
    chk("bp.d0.in_ready_low", EW'(ir[0]), '0);
    chk("bp.d2.in_ready_low", EW'(ir[2]), '0);
    chk("bp.d0.head_A", EW'(od0[31:0]), EW'(32'hAAAA0001));
    out_ready = 1'b1; #1;
    chk("bp.d1.in_ready_follows_hi", EW'(ir[1]), EW'(1));
    chk("bp.d0.in_ready_no_comb", EW'(ir[0]), '0);
    out_ready = 1'b0; #1;
    chk("bp.d1.in_ready_follows_lo", EW'(ir[1]), '0);
    cyc();
    chk("bp.d0.head_A_stable", EW'(od0[31:0]), EW'(32'hAAAA0001));
    cyc();
    chk("bp.d0.stall3", EW'(sc0), EW'(3));
    chk("bp.d1.stall3", EW'(sc1), EW'(3));
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    exp_n = 2; exp_w[0] = 32'hAAAA0001; exp_w[1] = 32'hBBBB0002;
    check_cap("bp");

    // Flush while the skid entry is occupied
    cap_clear();
    out_ready = 1'b0;
    push_word(8'hF1, 32'h0F0F0001);
    cyc();
    push_word(8'hF2, 32'h0F0F0002);
    cyc();
    chk("fl.d0.in_skid", EW'(ir[0]), '0);
    flush = 1'b1;
    push_word(8'hC3, 32'hCCCC0003);
    #1;
    chk("fl.d0.in_ready_flush", EW'(ir[0]), EW'(1));
    cyc();
    flush = 1'b0;
    out_ready = 1'b1;
    push_word(8'h0D, 32'hDDDD0004);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("fl.d%0d.out_valid", k), EW'(ov[k]), '0);
      chk($sformatf("fl.d%0d.out_ctrl", k), EW'(f_oc(k)), '0);
    end
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    exp_n = 1; exp_w[0] = 32'hDDDD0004;
    check_cap("flush");
    cap_en = 1'b0;

    // Stall-counter saturation on the 4-bit build
    out_ready = 1'b0;
    push_word(8'h0E, 32'hEEEE0005);
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat.d2.at15", EW'(sc2), EW'(15));
    cyc();
    cyc();
    chk("sat.d2.stays15", EW'(sc2), EW'(15));
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) chk($sformatf("sat.d%0d.rst_clears", k), EW'(f_sc(k)), '0);
    cyc();

    // Randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++) begin
      rst       = ($urandom % 100) == 0;
      flush     = ($urandom % 25) == 0;
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      rand_data();
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
